// File: rtl/posit_div_core.sv
// posit_div_core: multi-cycle posit quotient datapath (restoring divide, normalise, RNE round, range clamp)
module posit_div_core #(
    parameter int N      = 32,
    parameter int ES     = 3,
    parameter int K_BITS = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sign_a,
    input  logic              sign_b,
    input  logic [K_BITS-1:0] k_a,
    input  logic [K_BITS-1:0] k_b,
    input  logic [ES-1:0]     exp_a,
    input  logic [ES-1:0]     exp_b,
    input  logic [N-1:0]      mant_a,
    input  logic [N-1:0]      mant_b,
    input  logic              zero_a,
    input  logic              nar_a,
    input  logic              zero_b,
    input  logic              nar_b,
    output logic              sign_out,
    output logic [K_BITS-1:0] k_out,
    output logic [ES-1:0]     exp_out,
    output logic [N-1:0]      mant_out,
    output logic              zero_out,
    output logic              nar_out,
    output logic              ovf,
    output logic              unf,
    output logic              busy,
    output logic              done
);
    localparam int SW = K_BITS + ES + 1;
    localparam int CW = $clog2(N + 2);
    localparam logic signed [SW-1:0] S_MAX = SW'((2**(K_BITS-1) - 1) * (2**ES) - 1);
    localparam logic signed [SW-1:0] S_MIN = SW'(-((2**(K_BITS-1) - 1) * (2**ES)));
    localparam logic [K_BITS-1:0] K_MAX = K_BITS'(2**(K_BITS-1) - 2);
    localparam logic [K_BITS-1:0] K_MIN = K_BITS'(-(2**(K_BITS-1) - 1));
    localparam logic [N-1:0] HID = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, DIV, NORM, ROUND, DONE} state_t;
    state_t state, state_n;

    logic                 sign_q, g, s;
    logic signed [SW-1:0] scale, sc_r;
    logic [N:0]           r, r_sub, m_inc;
    logic [N+1:0]         q;
    logic [N-1:0]         b_m, m, m_r;
    logic [CW-1:0]        cnt;
    logic                 special, ge, inc, c;

    always_comb begin
        special = nar_a | nar_b | zero_b | zero_a;
        ge      = r >= {1'b0, b_m};
        r_sub   = ge ? r - {1'b0, b_m} : r;
        inc     = g & (s | m[0]);
        m_inc   = {1'b0, m} + (N+1)'(inc);
        c       = m_inc[N];
        m_r     = c ? HID : m_inc[N-1:0];
        sc_r    = scale + SW'(c);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? (special ? DONE : DIV) : IDLE;
            DIV:     state_n = (cnt == CW'(N + 1)) ? NORM : DIV;
            NORM:    state_n = ROUND;
            ROUND:   state_n = DONE;
            default: state_n = IDLE;
        endcase
        busy = state != IDLE;
        done = state == DONE;
    end

    always_ff @(posedge clk) state <= rst ? IDLE : state_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            {sign_out, k_out, exp_out, mant_out, zero_out, nar_out, ovf, unf} <= '0;
            {sign_q, g, s, scale, r, q, b_m, m, cnt} <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    {sign_out, k_out, exp_out, mant_out, zero_out, nar_out, ovf, unf} <= '0;
                    // NaR dominates zero: 0/0 and NaR/0 are both NaR
                    nar_out  <= nar_a | nar_b | zero_b;
                    zero_out <= !(nar_a | nar_b | zero_b) & zero_a;
                    sign_q   <= sign_a ^ sign_b;
                    scale    <= $signed({k_a[K_BITS-1], k_a, exp_a}) - $signed({k_b[K_BITS-1], k_b, exp_b});
                    r        <= {1'b0, mant_a};
                    b_m      <= mant_b;
                    q        <= '0;
                    cnt      <= '0;
                end
                DIV: begin
                    r   <= {r_sub[N-1:0], 1'b0};
                    q   <= {q[N:0], ge};
                    cnt <= cnt + 1'b1;
                end
                NORM: begin
                    m     <= q[N+1] ? q[N+1:2] : q[N:1];
                    g     <= q[N+1] ? q[1] : q[0];
                    s     <= (q[N+1] & q[0]) | (r != '0);
                    scale <= q[N+1] ? scale : scale - SW'(1);
                end
                ROUND: begin
                    sign_out <= sign_q;
                    ovf      <= sc_r > S_MAX;
                    unf      <= sc_r < S_MIN;
                    k_out    <= sc_r > S_MAX ? K_MAX : sc_r < S_MIN ? K_MIN : K_BITS'(sc_r >>> ES);
                    exp_out  <= (sc_r > S_MAX || sc_r < S_MIN) ? '0 : sc_r[ES-1:0];
                    mant_out <= (sc_r > S_MAX || sc_r < S_MIN) ? HID : m_r;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_posit_div_core.sv
// tb_posit_div_core: directed vectors and multi-cycle corner sequences for posit_div_core
module tb_posit_div_core;
    logic        clk = 0, rst = 1, start = 0;
    logic        sign_a = 0, sign_b = 0, zero_a = 0, nar_a = 0, zero_b = 0, nar_b = 0;
    logic [5:0]  k_a = 0, k_b = 0;
    logic [2:0]  exp_a = 0, exp_b = 0;
    logic [31:0] mant_a = 0, mant_b = 0;
    logic        sign_out, zero_out, nar_out, ovf, unf, busy, done;
    logic [5:0]  k_out;
    logic [2:0]  exp_out;
    logic [31:0] mant_out;
    int          n_pass = 0, n_total = 0;

    posit_div_core dut (
        .clk(clk), .rst(rst), .start(start),
        .sign_a(sign_a), .sign_b(sign_b), .k_a(k_a), .k_b(k_b),
        .exp_a(exp_a), .exp_b(exp_b), .mant_a(mant_a), .mant_b(mant_b),
        .zero_a(zero_a), .nar_a(nar_a), .zero_b(zero_b), .nar_b(nar_b),
        .sign_out(sign_out), .k_out(k_out), .exp_out(exp_out), .mant_out(mant_out),
        .zero_out(zero_out), .nar_out(nar_out), .ovf(ovf), .unf(unf),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic sa; logic [5:0] ka; logic [2:0] ea; logic [31:0] ma; logic za; logic na;
        logic sb; logic [5:0] kb; logic [2:0] eb; logic [31:0] mb; logic zb; logic nb;
        int lat; logic s; logic [5:0] k; logic [2:0] e; logic [31:0] m; logic [3:0] f;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic apply(input vec_t v);
        {sign_a, k_a, exp_a, mant_a, zero_a, nar_a} = {v.sa, v.ka, v.ea, v.ma, v.za, v.na};
        {sign_b, k_b, exp_b, mant_b, zero_b, nar_b} = {v.sb, v.kb, v.eb, v.mb, v.zb, v.nb};
    endtask

    task automatic run_vec(input int i);
        int lat;
        @(negedge clk);
        apply(vecs[i]);
        start = 1;
        @(negedge clk);
        start = 0;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
        check($sformatf("v%0d sign", i), 64'(sign_out), 64'(vecs[i].s));
        check($sformatf("v%0d k", i), 64'(k_out), 64'(vecs[i].k));
        check($sformatf("v%0d exp", i), 64'(exp_out), 64'(vecs[i].e));
        check($sformatf("v%0d mant", i), 64'(mant_out), 64'(vecs[i].m));
        check($sformatf("v%0d flags", i), 64'({zero_out, nar_out, ovf, unf}), 64'(vecs[i].f));
        @(negedge clk);
        check($sformatf("v%0d done/busy after", i), 64'({done, busy}), 64'(0));
    endtask

    // cycle 0 is the start cycle; restart/extra re-pulse start, rst_at pulses rst
    task automatic run_seq(input string nm, input int restart, input int extra, input int rst_at, input int exp_done);
        int ndone = 0, first = 0;
        apply(vecs[0]);
        @(negedge clk);
        start = 1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first == 0) first = cyc;
            end
            if (rst_at != 0 && cyc == rst_at + 1) begin
                check({nm, " busy after rst"}, 64'({busy, done}), 64'(0));
                check({nm, " outputs after rst"}, 64'({sign_out, k_out, exp_out, mant_out, zero_out, nar_out, ovf, unf}), 64'(0));
            end
            start = (cyc == restart || cyc == extra);
            rst   = (cyc == rst_at);
        end
        start = 0;
        rst = 0;
        check({nm, " done count"}, 64'(ndone), 64'(1));
        check({nm, " done cycle"}, 64'(first), 64'(exp_done));
        check({nm, " mant"}, 64'(mant_out), 64'h80000000);
    endtask

    initial begin
        vecs[0] = '{1'b0, 6'd0, 3'd0, 32'h80000000, 1'b0, 1'b0, 1'b0, 6'd0, 3'd0, 32'h80000000, 1'b0, 1'b0,
                    37, 1'b0, 6'd0, 3'd0, 32'h80000000, 4'b0000};
        vecs[1] = '{1'b0, 6'd0, 3'd0, 32'h80000000, 1'b0, 1'b0, 1'b0, 6'd0, 3'd0, 32'hC0000000, 1'b0, 1'b0,
                    37, 1'b0, 6'h3F, 3'd7, 32'hAAAAAAAB, 4'b0000};
        vecs[2] = '{1'b1, 6'd0, 3'd1, 32'hC0000000, 1'b0, 1'b0, 1'b0, 6'd0, 3'd0, 32'hC0000000, 1'b0, 1'b0,
                    37, 1'b1, 6'd0, 3'd1, 32'h80000000, 4'b0000};
        vecs[3] = '{1'b0, 6'd0, 3'd0, 32'h80000000, 1'b0, 1'b0, 1'b0, 6'd0, 3'd0, 32'h0, 1'b1, 1'b0,
                    1, 1'b0, 6'd0, 3'd0, 32'h0, 4'b0100};
        vecs[4] = '{1'b1, 6'd0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b0, 6'd0, 3'd0, 32'h80000000, 1'b0, 1'b0,
                    1, 1'b0, 6'd0, 3'd0, 32'h0, 4'b1000};
        vecs[5] = '{1'b0, 6'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0, 6'd0, 3'd0, 32'h0, 1'b1, 1'b0,
                    1, 1'b0, 6'd0, 3'd0, 32'h0, 4'b0100};
        vecs[6] = '{1'b0, 6'd30, 3'd7, 32'h80000000, 1'b0, 1'b0, 1'b0, 6'h21, 3'd0, 32'h80000000, 1'b0, 1'b0,
                    37, 1'b0, 6'd30, 3'd0, 32'h80000000, 4'b0010};
        vecs[7] = '{1'b0, 6'h21, 3'd0, 32'h80000000, 1'b0, 1'b0, 1'b0, 6'd30, 3'd7, 32'h80000000, 1'b0, 1'b0,
                    37, 1'b0, 6'h21, 3'd0, 32'h80000000, 4'b0001};
        vecs[8] = '{1'b0, 6'd0, 3'd0, 32'hC0000000, 1'b0, 1'b0, 1'b1, 6'd0, 3'd0, 32'h80000000, 1'b0, 1'b0,
                    37, 1'b1, 6'd0, 3'd0, 32'hC0000000, 4'b0000};

        repeat (3) @(negedge clk);
        check("reset busy/done", 64'({busy, done}), 64'(0));
        check("reset outputs", 64'({sign_out, k_out, exp_out, mant_out, zero_out, nar_out, ovf, unf}), 64'(0));
        rst = 0;

        for (int i = 0; i < 9; i++) run_vec(i);

        run_seq("restart ignored", 5, 37, 0, 37);
        repeat (2) @(negedge clk);
        run_seq("rst abort", 0, 12, 10, 49);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/posit_div_core.md
POSIT_DIV_CORE -- requirements
Module: posit_div_core

Interface
REQ-001 Parameters: N, 32, posit width / mantissa width; ES, 3, exponent bits; K_BITS, 6, signed regime width; only defaults are verified.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  one-cycle request; sampled only in IDLE.
REQ-005 sign_a, sign_b  in  1 each  operand signs.
REQ-006 k_a, k_b  in  K_BITS each  two's-complement regime values.
REQ-007 exp_a, exp_b  in  ES each  unsigned exponent fields.
REQ-008 mant_a, mant_b  in  N each  Q1.31 significand, hidden 1 at bit 31.
REQ-009 zero_a, nar_a, zero_b, nar_b  in  1 each  special-value flags from the decoders.
REQ-010 sign_out  out  1  quotient sign.
REQ-011 k_out  out  K_BITS; exp_out  out  ES; mant_out  out  N (Q1.31): quotient fields for the encoder.
REQ-012 zero_out, nar_out, ovf, unf  out  1 each  special-result/saturation flags.
REQ-013 busy  out  1  high in any state other than IDLE; done  out  1  one-cycle result-valid pulse.

Function
REQ-014 States: IDLE, DIV, NORM, ROUND, DONE; DONE -> IDLE unconditionally next cycle.
REQ-015 IDLE + start at cycle T: all operand inputs registered; inputs ignored at all other times.
REQ-016 Special path: nar_a|nar_b|zero_b -> nar_out=1; else zero_a -> zero_out=1; either case -> DONE at T+1, sign_out/k_out/exp_out/mant_out = 0, division skipped.
REQ-017 Normal path: scale_x = k_x*8 + exp_x (10-bit signed); scale_q = scale_a - scale_b; sign_out = sign_a ^ sign_b.
REQ-018 DIV: restoring division, 34 cycles (T+1..T+34); remainder R (33-bit) init mant_a; per cycle: if R >= mant_b then qbit=1, R -= mant_b, else qbit=0; R <<= 1; qbit shifted into q[33:0] from LSB, giving q[33] weight 2^0.
REQ-019 NORM (T+35): if q[33]=1 then m=q[33:2], g=q[1], s=q[0]|(R!=0); else m=q[32:1], g=q[0], s=(R!=0), scale_q -= 1.
REQ-020 ROUND (T+36): round-to-nearest-even: increment m when g & (s | m[0]); increment carry-out -> m=0x80000000, scale_q += 1.
REQ-021 Range: scale_q > 247 -> ovf=1, k_out=30, exp_out=0, mant_out=0x80000000; scale_q < -248 -> unf=1, k_out=-31, exp_out=0, mant_out=0x80000000.
REQ-022 Else k_out = scale_q >>> 3 (arithmetic), exp_out = scale_q[2:0], mant_out = m.
REQ-023 Normal-path done pulse at T+37 (latency 37 cycles from start); special path done at T+1.
REQ-024 All outputs except done/busy hold until next accepted start; all flags cleared at acceptance of a new start.
REQ-025 start while busy (including the DONE cycle) is ignored, no queuing.
REQ-026 done and busy never high in the same cycle as IDLE acceptance; done high exactly one cycle per accepted start.

Reset
REQ-027 rst=1 at a clock edge -> state IDLE, all outputs 0, q/R/scale cleared, regardless of current state.
REQ-028 rst asserted mid-DIV aborts the operation; no done pulse is produced for it.
REQ-029 First start accepted the cycle after rst deasserts.

Verification
REQ-030 1.0/1.0 (k=0,exp=0,mant=0x80000000 both) -> done at T+37, sign 0, k_out=0, exp_out=0, mant_out=0x80000000, flags 0.
REQ-031 1.0/1.5 (mant_b=0xC0000000) -> k_out=6'b111111, exp_out=7, mant_out=0xAAAAAAAB (rounded up), sign 0.
REQ-032 -3.0/1.5 (sign_a=1, exp_a=1, mant_a=0xC0000000; exp_b=0, mant_b=0xC0000000) -> sign_out=1, k_out=0, exp_out=1, mant_out=0x80000000.
REQ-033 zero_b=1 -> nar_out=1, done at T+1; zero_a=1 with b=1.0 -> zero_out=1, done at T+1; nar_a with zero_b -> nar_out only.
REQ-034 a: k=30,exp=7; b: k=-31,exp=0 -> ovf=1, k_out=30, exp_out=0, mant_out=0x80000000; swapped operands -> unf=1, k_out=-31.
REQ-035 start re-pulsed at T+5 -> ignored, single done at T+37; rst at T+10 -> busy=0 at T+11, no done; new start at T+12 -> done at T+49.
